// File: rtl/ptr_sync_gray_if.sv
// ----------------------------------------------------------------------------
// ptr_sync_gray_if
// Bundles the cross-domain pointer and its synchronized views for
// ptr_sync_gray.
//   rptr       : Gray-coded pointer from the foreign clock domain (asynchronous)
//   err_clr    : synchronous clear of the sticky integrity flag
//   wq_rptr    : synchronized Gray pointer
//   wq_rbin    : binary equivalent of wq_rptr, cycle-aligned with it
//   wq_changed : one-cycle pulse when wq_rptr takes a new value
//   wq_valid   : synchronizer chain holds only sampled data
//   wq_err     : sticky flag, synchronized pointer moved by more than one bit
// master drives rptr/err_clr and observes the results; slave is the synchronizer.
// ----------------------------------------------------------------------------
interface ptr_sync_gray_if #(
    parameter int ADDRSIZE = 9
);
    logic [ADDRSIZE:0] rptr;
    logic              err_clr;
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] wq_rbin;
    logic              wq_changed;
    logic              wq_valid;
    logic              wq_err;

    modport master (
        output rptr,
        output err_clr,
        input  wq_rptr,
        input  wq_rbin,
        input  wq_changed,
        input  wq_valid,
        input  wq_err
    );

    modport slave (
        input  rptr,
        input  err_clr,
        output wq_rptr,
        output wq_rbin,
        output wq_changed,
        output wq_valid,
        output wq_err
    );
endinterface

// File: rtl/ptr_sync_gray.sv
// ----------------------------------------------------------------------------
// ptr_sync_gray
// Carries a Gray-coded pointer from a foreign clock domain into the wclk
// domain through SYNC_STAGES flops, and derives from the synchronized value a
// registered binary conversion, a change pulse, a post-reset valid flag and a
// sticky Gray-integrity error flag. Every output comes straight from a flop.
//
// Ports:
//   wclk   : destination-domain clock, all flops on posedge
//   wrst_n : asynchronous active-low reset
//   bus    : ptr_sync_gray_if slave modport (rptr, err_clr in; wq_* out)
//
// Parameters:
//   ADDRSIZE    : pointer is ADDRSIZE+1 bits (extra MSB for wrap detection)
//   SYNC_STAGES : synchronizer depth, legal 2..4
//   CHECK_EN    : 1 = integrity checker present, 0 = wq_err held at 0
// ----------------------------------------------------------------------------
module ptr_sync_gray #(
    parameter int ADDRSIZE    = 9,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_EN    = 1
) (
    input  logic             wclk,
    input  logic             wrst_n,
    ptr_sync_gray_if.slave   bus
);

    localparam int          W        = ADDRSIZE + 1;
    localparam logic [2:0]  FILL_MAX = 3'(SYNC_STAGES);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("ptr_sync_gray: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];
    logic [W-1:0] rbin_q, rbin_d;
    logic         changed_q, changed_d;
    logic         valid_q, valid_d;
    logic [2:0]   fill_q, fill_d;
    logic         err_q, err_d;

    // Bit difference between the value about to enter the last stage and the
    // value currently there; drives both the change pulse and the checker.
    logic [W-1:0] step_diff;
    assign step_diff = sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = bus.rptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // The binary view is computed from the next-to-last stage so it lands on
    // the same edge as the Gray value it describes.
    // The pre-edge valid gates the pulse, so reset zeros filling the chain
    // never count as a change.
    always_comb begin
        rbin_d    = gray2bin(sync_q[SYNC_STAGES-2]);
        changed_d = valid_q & (|step_diff);
        fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 3'd1;
        valid_d   = valid_q | (fill_q == FILL_MAX - 3'd1);
    end

    generate
        if (CHECK_EN != 0) begin : g_check
            // More than one bit set: clearing the lowest set bit leaves bits.
            logic multi_bit;
            assign multi_bit = |(step_diff & (step_diff - W'(1)));

            // A new violation takes priority over a clear in the same cycle.
            always_comb begin
                err_d = err_q;
                if (valid_q && multi_bit) begin
                    err_d = 1'b1;
                end else if (bus.err_clr) begin
                    err_d = 1'b0;
                end
            end
        end else begin : g_no_check
            assign err_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rbin_q    <= '0;
            changed_q <= 1'b0;
            valid_q   <= 1'b0;
            fill_q    <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            rbin_q    <= rbin_d;
            changed_q <= changed_d;
            valid_q   <= valid_d;
            fill_q    <= fill_d;
            err_q     <= err_d;
        end
    end

    assign bus.wq_rptr    = sync_q[SYNC_STAGES-1];
    assign bus.wq_rbin    = rbin_q;
    assign bus.wq_changed = changed_q;
    assign bus.wq_valid   = valid_q;
    assign bus.wq_err     = err_q;

endmodule
